// File: rtl/quadrature_gen.sv
// Quadrature A/B generator behind a 4-word register port: programmable edge rate, direction, edge count, position.
// Define QUADRATURE_GEN_INDEX_EN to add the revolution counter and index pulse z.
module quadrature_gen #(
  parameter logic [15:0] DIV_RESET = 16'd0,
  parameter int unsigned PPR       = 96
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  reg_we,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] reg_data,
  output logic [31:0] reg_q,
  output logic        a,
  output logic        b,
  output logic        z
);
  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_DIV   = 2'd1;
  localparam logic [1:0] ADDR_STEPS = 2'd2;
  localparam logic [1:0] ADDR_POS   = 2'd3;

  logic        en_reg, en_next;
  logic        cont_reg, cont_next;
  logic        dir_reg, dir_next;
  logic        done_reg, done_next;
  logic [15:0] divider_reg, divider_next;
  logic [15:0] steps_reg, steps_next;
  logic [15:0] position_reg, position_next;
  logic [15:0] prescaler_reg, prescaler_next;
  logic [1:0]  phase_reg, phase_next;
  logic        wr_lo, wr_ctrl, wr_div, wr_steps, wr_pos;
  logic        active, step, done_set, done_clr;
  logic [15:0] idx_rd;
  logic        unused_ok;

  assign wr_lo    = &reg_we[1:0];
  assign wr_ctrl  = wr_lo && (reg_addr == ADDR_CTRL);
  assign wr_div   = wr_lo && (reg_addr == ADDR_DIV);
  assign wr_steps = wr_lo && (reg_addr == ADDR_STEPS);
  assign wr_pos   = wr_lo && (reg_addr == ADDR_POS);

  assign active   = en_reg && (cont_reg || (steps_reg != 16'd0));
  assign step     = active && (prescaler_reg >= divider_reg);
  // A STEPS write in the step cycle overrides the decrement, so it cannot complete the run.
  assign done_set = step && !cont_reg && !wr_steps && (steps_reg == 16'd1);
  assign done_clr = wr_ctrl && reg_data[4];

  always_comb begin
    en_next        = en_reg;
    cont_next      = cont_reg;
    dir_next       = dir_reg;
    divider_next   = divider_reg;
    steps_next     = steps_reg;
    position_next  = position_reg;
    phase_next     = phase_reg;
    prescaler_next = 16'd0;
    if (active && !step) prescaler_next = prescaler_reg + 16'd1;
    if (step) begin
      phase_next    = dir_reg ? phase_reg + 2'd1 : phase_reg - 2'd1;
      position_next = dir_reg ? position_reg + 16'd1 : position_reg - 16'd1;
      if (!cont_reg) steps_next = steps_reg - 16'd1;
    end
    if (wr_ctrl) begin
      en_next   = reg_data[0];
      cont_next = reg_data[1];
      dir_next  = reg_data[2];
    end
    if (wr_div)   divider_next  = reg_data[15:0];
    if (wr_steps) steps_next    = reg_data[15:0];
    if (wr_pos)   position_next = reg_data[15:0];
    done_next = done_set || (done_reg && !done_clr);
  end

  // Phase index 0..3 maps to (a,b) = 00, 10, 11, 01.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_reg        <= 1'b0;
      cont_reg      <= 1'b0;
      dir_reg       <= 1'b0;
      done_reg      <= 1'b0;
      divider_reg   <= DIV_RESET;
      steps_reg     <= 16'd0;
      position_reg  <= 16'd0;
      prescaler_reg <= 16'd0;
      phase_reg     <= 2'd0;
      a             <= 1'b0;
      b             <= 1'b0;
    end else begin
      en_reg        <= en_next;
      cont_reg      <= cont_next;
      dir_reg       <= dir_next;
      done_reg      <= done_next;
      divider_reg   <= divider_next;
      steps_reg     <= steps_next;
      position_reg  <= position_next;
      prescaler_reg <= prescaler_next;
      phase_reg     <= phase_next;
      a             <= phase_next[1] ^ phase_next[0];
      b             <= phase_next[1];
    end
  end

`ifdef QUADRATURE_GEN_INDEX_EN
  localparam logic [15:0] IDX_LAST = 16'(PPR - 1);

  logic [15:0] idx_reg, idx_next;
  logic        z_next;

  always_comb begin
    idx_next = idx_reg;
    z_next   = z;
    if (wr_pos) begin
      idx_next = 16'd0;
      z_next   = 1'b0;
    end else if (step) begin
      if (dir_reg) idx_next = (idx_reg >= IDX_LAST) ? 16'd0 : idx_reg + 16'd1;
      else         idx_next = (idx_reg == 16'd0) ? IDX_LAST : idx_reg - 16'd1;
      z_next = (idx_next == 16'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg <= 16'd0;
      z       <= 1'b0;
    end else begin
      idx_reg <= idx_next;
      z       <= z_next;
    end
  end

  assign idx_rd    = idx_reg;
  assign unused_ok = ^reg_data[31:16];
`else
  assign z         = 1'b0;
  assign idx_rd    = 16'd0;
  assign unused_ok = ^{reg_data[31:16], 32'(PPR)};
`endif

  always_comb begin
    reg_q = 32'd0;
    case (reg_addr)
      ADDR_CTRL:  reg_q = {idx_rd, 11'd0, done_reg, active, dir_reg, cont_reg, en_reg};
      ADDR_DIV:   reg_q = {16'd0, divider_reg};
      ADDR_STEPS: reg_q = {16'd0, steps_reg};
      default:    reg_q = {16'd0, position_reg};
    endcase
  end

endmodule
